// File: rtl/hilo_mult_div_if.sv
// Request/result bundle between the control unit and the HI/LO multiply/divide unit.
interface hilo_mult_div_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic             op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             busy;
    logic             done;
    logic             div_zero;
    logic [WIDTH-1:0] HIout;
    logic [WIDTH-1:0] LOout;

    // Control unit side: issues requests, reads HI/LO and status.
    modport master (
        output start, op, A, B,
        input  busy, done, div_zero, HIout, LOout
    );

    // Arithmetic unit side.
    modport slave (
        input  start, op, A, B,
        output busy, done, div_zero, HIout, LOout
    );
endinterface

// File: rtl/hilo_mult_div.sv
// Multicycle signed MULT (radix-2 Booth) / DIV (restoring, on magnitudes) unit.
// One iteration per clock; HI/LO are written only on the completing edge and held otherwise.
module hilo_mult_div #(
    parameter int WIDTH = 32
) (
    input logic            clk,
    input logic            reset,
    hilo_mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi, lo;
    logic             busy, done, div_zero;

    // Booth accumulator {upper[W:0], multiplier[W-1:0], q_-1}. The upper part carries one
    // extra sign bit so subtracting the most-negative multiplicand cannot wrap.
    logic [2*WIDTH+1:0] acc;
    logic [WIDTH:0]     mcand;
    // Restoring divider: partial remainder (one guard bit), dividend/quotient shifter, divisor.
    logic [WIDTH:0]     rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   dvsr;
    logic               neg_q, neg_r;

    logic               accept;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     booth_sum;
    logic [2*WIDTH+1:0] acc_next;
    logic [WIDTH:0]     rem_shift, rem_diff, rem_next;
    logic [WIDTH-1:0]   quo_next;
    logic [WIDTH-1:0]   quo_final, rem_final;

    assign accept = bus.start && (state == S_IDLE || state == S_DONE);
    // The most-negative value maps onto itself, which is its correct unsigned magnitude.
    assign a_mag  = bus.A[WIDTH-1] ? -bus.A : bus.A;
    assign b_mag  = bus.B[WIDTH-1] ? -bus.B : bus.B;

    // One Booth step: add/subtract the multiplicand per the bit pair, then arithmetic shift.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        booth_sum = acc[2*WIDTH+1:WIDTH+1];
        case (acc[1:0])
            2'b01:   booth_sum = acc[2*WIDTH+1:WIDTH+1] + mcand;
            2'b10:   booth_sum = acc[2*WIDTH+1:WIDTH+1] - mcand;
            default: booth_sum = acc[2*WIDTH+1:WIDTH+1];
        endcase
        acc_next = {booth_sum[WIDTH], booth_sum, acc[WIDTH:1]};
    end

    // One restoring-division step plus the sign fix-up used on the final edge.
    always_comb begin
        rem_shift = {rem[WIDTH-1:0], quo[WIDTH-1]};
        rem_diff  = rem_shift - {1'b0, dvsr};
        rem_next  = rem_shift;
        quo_next  = {quo[WIDTH-2:0], 1'b0};
        if (!rem_diff[WIDTH]) begin
            rem_next = rem_diff;
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end
        quo_final = neg_q ? -quo_next : quo_next;
        rem_final = neg_r ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];
    end

    // Datapath: load operands on an accepted start, otherwise iterate in the active state.
    // NOTE: these registers are deliberately not reset; an accepted start always loads them
    // before any result is derived from them.
    always_ff @(posedge clk) begin
        if (accept) begin
            mcand <= {bus.A[WIDTH-1], bus.A};
            acc   <= {{(WIDTH + 1){1'b0}}, bus.B, 1'b0};
            rem   <= '0;
            quo   <= a_mag;
            dvsr  <= b_mag;
            neg_q <= bus.A[WIDTH-1] ^ bus.B[WIDTH-1];
            neg_r <= bus.A[WIDTH-1];
        end else if (state == S_MULT) begin
            acc <= acc_next;
        end else if (state == S_DIV) begin
            rem <= rem_next;
            quo <= quo_next;
        end
    end

    // Control FSM with registered status outputs and the architectural HI/LO registers.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            hi       <= '0;
            lo       <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    if (bus.start) begin
                        div_zero <= 1'b0;
                        cnt      <= CW'(WIDTH);
                        if (!bus.op) begin
                            state <= S_MULT;
                            busy  <= 1'b1;
                        end else if (bus.B != '0) begin
                            state <= S_DIV;
                            busy  <= 1'b1;
                        end else begin
                            state    <= S_DONE;
                            done     <= 1'b1;
                            div_zero <= 1'b1;
                        end
                    end
                end
                S_MULT: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi    <= acc_next[2*WIDTH:WIDTH+1];
                        lo    <= acc_next[WIDTH:1];
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                S_DIV: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == CW'(1)) begin
                        hi    <= rem_final;
                        lo    <= quo_final;
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy     = busy;
    assign bus.done     = done;
    assign bus.div_zero = div_zero;
    assign bus.HIout    = hi;
    assign bus.LOout    = lo;
endmodule

// File: tb/tb_hilo_mult_div.sv
// Randomized + directed bench for hilo_mult_div against a plain-arithmetic HI/LO model.
module tb_hilo_mult_div;
    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    hilo_mult_div_if #(.WIDTH(W)) bus ();
    hilo_mult_div #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

    int vectors = 0;
    int miscompares = 0;

    // Reference architectural state.
    logic [W-1:0] ref_hi, ref_lo;
    logic         ref_dz;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model of one operation from the signed-arithmetic definition.
    task automatic model(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        logic signed [63:0] sa, sb, p, q, r;
        sa = 64'($signed(a));
        sb = 64'($signed(b));
        ref_dz = 1'b0;
        if (!o) begin
            p = sa * sb;
            ref_hi = p[63:32];
            ref_lo = p[31:0];
        end else if (b == '0) begin
            ref_dz = 1'b1;
        end else begin
            q = sa / sb;
            r = sa % sb;
            ref_hi = r[31:0];
            ref_lo = q[31:0];
        end
    endtask

    // Presents a request for one edge, then scrambles the inputs.
    task automatic start_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.op    = 1'($urandom);
        bus.A     = $urandom;
        bus.B     = $urandom;
    endtask

    // Runs one operation; returns in the done cycle so the next call is back-to-back.
    task automatic run_op(input logic o, input logic [W-1:0] a, input logic [W-1:0] b,
                          input bit poke);
        logic [W-1:0] held_hi, held_lo;
        int exp_lat, e, busy_n;
        bit seen;
        held_hi = ref_hi;
        held_lo = ref_lo;
        exp_lat = (o && b == '0) ? 0 : W;
        start_op(o, a, b);
        e = 0;
        busy_n = 0;
        seen = 1'b0;
        while (e < 200) begin
            if (bus.done) begin
                seen = 1'b1;
                break;
            end
            if (bus.busy) busy_n++;
            if (e == 0) check("dz_clear_on_start", 64'(bus.div_zero), 64'(0));
            if (e == W / 2) begin
                check("hi_hold_mid", 64'(bus.HIout), 64'(held_hi));
                check("lo_hold_mid", 64'(bus.LOout), 64'(held_lo));
            end
            bus.start = poke && (e == 4);
            if (poke && e == 4) begin
                bus.op = 1'b1;
                bus.B  = '0;
            end
            @(negedge clk);
            e++;
        end
        bus.start = 1'b0;
        model(o, a, b);
        check("done_seen", 64'(seen), 64'(1));
        check("latency", 64'(e), 64'(exp_lat));
        check("busy_cycles", 64'(busy_n), 64'(exp_lat));
        check("busy_at_done", 64'(bus.busy), 64'(0));
        check("hi", 64'(bus.HIout), 64'(ref_hi));
        check("lo", 64'(bus.LOout), 64'(ref_lo));
        check("div_zero", 64'(bus.div_zero), 64'(ref_dz));
    endtask

    // One idle cycle after a completion: done must have dropped, results held.
    task automatic idle_check();
        @(negedge clk);
        check("done_one_cycle", 64'(bus.done), 64'(0));
        check("hi_idle", 64'(bus.HIout), 64'(ref_hi));
        check("lo_idle", 64'(bus.LOout), 64'(ref_lo));
    endtask

    function automatic logic [W-1:0] pick_operand();
        logic [W-1:0] v;
        case ($urandom_range(0, 5))
            0: v = 32'h8000_0000;
            1: v = 32'hFFFF_FFFF;
            2: v = 32'(1);
            3: v = 32'($urandom_range(0, 20)) - 32'd10;
            default: v = $urandom;
        endcase
        return v;
    endfunction

    initial begin
        int dones;
        logic o;
        logic [W-1:0] a, b;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        ref_hi = '0;
        ref_lo = '0;
        ref_dz = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hi", 64'(bus.HIout), 64'(0));
        check("rst_lo", 64'(bus.LOout), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_dz", 64'(bus.div_zero), 64'(0));
        reset = 1'b0;
        @(negedge clk);

        // Directed cases, chained back-to-back where the done cycle allows.
        run_op(1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0);
        idle_check();
        run_op(1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        idle_check();
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        run_op(1'b1, 32'd5, 32'd0, 1'b0);
        run_op(1'b0, 32'd2, 32'd3, 1'b0);
        run_op(1'b0, 32'd9, 32'd9, 1'b1);

        // Randomized mix, with occasional idle gaps and ignored mid-operation requests.
        for (int i = 0; i < 60; i++) begin
            o = 1'($urandom);
            a = pick_operand();
            b = ($urandom_range(0, 7) == 0) ? '0 : pick_operand();
            run_op(o, a, b, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) idle_check();
        end

        // Reset in the middle of a MULT discards it completely.
        start_op(1'b0, $urandom, $urandom);
        for (int e = 0; e < 10; e++) begin
            bus.start = (e == 4);
            @(negedge clk);
        end
        bus.start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        ref_hi = '0;
        ref_lo = '0;
        ref_dz = 1'b0;
        check("midrst_hi", 64'(bus.HIout), 64'(ref_hi));
        check("midrst_lo", 64'(bus.LOout), 64'(ref_lo));
        check("midrst_busy", 64'(bus.busy), 64'(0));
        check("midrst_dz", 64'(bus.div_zero), 64'(ref_dz));
        dones = 0;
        for (int e = 0; e < 40; e++) begin
            @(negedge clk);
            if (bus.done) dones++;
        end
        check("midrst_no_done", 64'(dones), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
